chip8_fetch_sequencer: RTL and testbench
========================================

CHIP8_FETCH_SEQUENCER -- requirements
Module: chip8_fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 12'h200: program counter value after reset.
REQ-002 SHALL have parameter STACK_DEPTH, default 16: number of return-address entries (power of two).
REQ-003 SHALL have port cpu_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port mem_req, output, 1 bit: byte read request to program memory.
REQ-006 SHALL have port mem_addr, output, 12 bits: byte address for the read request.
REQ-007 SHALL have port mem_ack, input, 1 bit: read complete; mem_rdata is valid in the same cycle.
REQ-008 SHALL have port mem_rdata, input, 8 bits: read data.
REQ-009 SHALL have port instr, output, 16 bits: last fetched instruction, big-endian (byte at PC is [15:8]).
REQ-010 SHALL have port instr_valid, output, 1 bit: instr is ready for the executor.
REQ-011 SHALL have port pc_op_valid, input, 1 bit: executor presents a PC update.
REQ-012 SHALL have port pc_op, input, 3 bits: NEXT=0, SKIP=1, JUMP=2, CALL=3, RET=4; codes 5-7 are treated as NEXT.
REQ-013 SHALL have port pc_target, input, 12 bits: destination for JUMP and CALL.
REQ-014 SHALL have port pc, output, 12 bits: current program counter.
REQ-015 SHALL have port sp, output, 4 bits: stack depth, number of valid entries modulo STACK_DEPTH.
REQ-016 SHALL have port stack_fault, output, 1 bit: sticky stack overflow/underflow flag; present only with CHIP8_STACK_GUARD_EN.

Function
REQ-017 SHALL implement the FSM states FETCH_HI, FETCH_LO and HOLD, plus FAULT when CHIP8_STACK_GUARD_EN is defined.
REQ-018 SHALL in FETCH_HI drive mem_req=1 and mem_addr=pc; on mem_ack, capture mem_rdata into instr[15:8] and go to FETCH_LO.
REQ-019 SHALL in FETCH_LO drive mem_req=1 and mem_addr=pc+1 (mod 4096); on mem_ack, capture mem_rdata into instr[7:0] and go to HOLD.
REQ-020 SHALL hold mem_req high and mem_addr stable until mem_ack, and ignore mem_ack when mem_req=0.
REQ-021 SHALL assert instr_valid only in HOLD, and keep instr stable from HOLD entry until the next FETCH_LO capture.
REQ-022 SHALL ignore pc_op_valid outside HOLD.
REQ-023 SHALL in HOLD with pc_op_valid update the PC per pc_op and go to FETCH_HI: NEXT pc+2; SKIP pc+4; JUMP pc_target; CALL push pc+2 then pc_target; RET pop.
REQ-024 SHALL compute all PC arithmetic modulo 4096 (12'hFFE+2 = 12'h000).
REQ-025 SHALL give a minimum of 3 cycles per instruction with zero-wait memory: FETCH_HI, FETCH_LO, then HOLD with an immediate op.
REQ-026 SHALL, without the guard, wrap sp on a CALL with a full stack (overwriting the oldest entry) and on a RET with an empty stack (returning stale contents).

Reset
REQ-027 SHALL on reset set pc=RESET_PC, sp=0, instr=16'h0000, instr_valid=0, mem_req=0 (in the reset cycle), stack_fault=0, and state=FETCH_HI.
REQ-028 SHALL let reset override any state, including mid-fetch with an outstanding request; a mem_ack in the reset cycle is discarded.
REQ-029 SHALL leave stack RAM contents unreset.

Configuration
REQ-030 SHALL, with CHIP8_STACK_GUARD_EN defined, treat CALL at sp=STACK_DEPTH-1 and RET at sp=0 as faults that leave pc and sp unchanged, set stack_fault=1, and enter FAULT.
REQ-031 SHALL in FAULT drive mem_req=0 and instr_valid=0 and remain there until reset.
REQ-032 SHALL, without CHIP8_STACK_GUARD_EN, omit the stack_fault port and the FAULT state, and apply REQ-026.

Structure
REQ-033 SHALL take the pc_op encoding enum, the FSM state enum and the 12-bit address typedef from the shared package chip8_pkg.
REQ-034 SHALL implement the stack in a sub-module chip8_call_stack (push/pop/full/empty, synchronous write, combinational top-of-stack read).

Verification
REQ-035 SHALL verify: reset, then zero-wait memory with bytes 0x200=8'h12, 0x201=8'h34 -> instr=16'h1234 and instr_valid in cycle 3 with pc=12'h200.
REQ-036 SHALL verify: mem_ack delayed 4 cycles in FETCH_HI -> mem_addr held at 12'h200 and mem_req held high throughout, with no instr change.
REQ-037 SHALL verify: CALL with pc_target=12'h300 at pc=12'h204 -> pc=12'h300 and sp=1; then RET -> pc=12'h206 and sp=0.
REQ-038 SHALL verify: SKIP at pc=12'hFFC -> pc=12'h000; NEXT at pc=12'hFFE -> pc=12'h000.
REQ-039 SHALL verify: 16 consecutive CALLs -> without the guard sp wraps to 0; with the guard the 16th CALL sets stack_fault, stops mem_req, and leaves pc unchanged.
REQ-040 SHALL verify: reset asserted in FETCH_LO while mem_ack=1 -> instr=0, pc=12'h200, and a clean fetch restarts after reset.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared types for the CHIP-8 fetch sequencer and its call stack.
// The FAULT state exists only when CHIP8_STACK_GUARD_EN is defined.
package chip8_pkg;

    typedef logic [11:0] addr_t;

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_SKIP = 3'd1,
        OP_JUMP = 3'd2,
        OP_CALL = 3'd3,
        OP_RET  = 3'd4
    } pc_op_e;

`ifdef CHIP8_STACK_GUARD_EN
    typedef enum logic [1:0] {
        FETCH_HI,
        FETCH_LO,
        HOLD,
        FAULT
    } state_e;
`else
    typedef enum logic [1:0] {
        FETCH_HI,
        FETCH_LO,
        HOLD
    } state_e;
`endif

    // All program-counter arithmetic wraps within the 4 KiB address space.
    function automatic addr_t pc_add(input addr_t base, input addr_t inc);
        return base + inc;
    endfunction

endpackage

// File: rtl/chip8_call_stack.sv
// Return-address stack: synchronous push, combinational top-of-stack read.
// The pointer wraps modulo DEPTH; RAM contents are deliberately not reset.
module chip8_call_stack
    import chip8_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [11:0]   push_data,
    output logic [11:0]   top,
    output logic [AW-1:0] count,
    output logic          full,
    output logic          empty
);

    addr_t         mem [DEPTH];
    logic [AW-1:0] ptr;

    assign count = ptr;
    assign empty = (ptr == '0);
    assign full  = (ptr == AW'(DEPTH - 1));
    assign top   = mem[ptr - AW'(1)];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (push) begin
            ptr <= ptr + AW'(1);
        end else if (pop) begin
            ptr <= ptr - AW'(1);
        end
    end

endmodule

// File: rtl/chip8_fetch_sequencer.sv
// CHIP-8 instruction fetch sequencer: two byte reads per instruction, then a
// hold until the executor supplies a PC update. CHIP8_STACK_GUARD_EN adds stack_fault.
module chip8_fetch_sequencer
    import chip8_pkg::*;
#(
    parameter logic [11:0] RESET_PC    = 12'h200,
    parameter int unsigned STACK_DEPTH = 16
) (
    input  logic        cpu_clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [11:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] instr,
    output logic        instr_valid,
    input  logic        pc_op_valid,
    input  logic [2:0]  pc_op,
    input  logic [11:0] pc_target,
    output logic [11:0] pc,
    output logic [3:0]  sp
`ifdef CHIP8_STACK_GUARD_EN
    ,
    output logic        stack_fault
`endif
);

`ifdef CHIP8_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int unsigned SW = $clog2(STACK_DEPTH);

    state_e        state;
    logic [7:0]    hi_byte;
    addr_t         seq_pc;
    addr_t         pc_next;
    addr_t         stack_top;
    logic          take_op;
    logic          call_op;
    logic          ret_op;
    logic          fault_op;
    logic          push;
    logic          pop;
    logic          stack_full;
    logic          stack_empty;
    logic [SW-1:0] stack_count;

    assign mem_req  = !reset && (state == FETCH_HI || state == FETCH_LO);
    assign mem_addr = (state == FETCH_LO) ? pc_add(pc, 12'd1) : pc;
    assign sp       = 4'(stack_count);
    assign seq_pc   = pc_add(pc, 12'd2);
    assign take_op  = !reset && (state == HOLD) && pc_op_valid;

    always_comb begin
        pc_next = seq_pc;
        call_op = 1'b0;
        ret_op  = 1'b0;
        case (pc_op_e'(pc_op))
            OP_SKIP: pc_next = pc_add(pc, 12'd4);
            OP_JUMP: pc_next = pc_target;
            OP_CALL: begin
                pc_next = pc_target;
                call_op = 1'b1;
            end
            OP_RET: begin
                pc_next = stack_top;
                ret_op  = 1'b1;
            end
            default: pc_next = seq_pc;
        endcase
    end

    assign fault_op = GUARD && ((call_op && stack_full) || (ret_op && stack_empty));
    assign push     = take_op && call_op && !fault_op;
    assign pop      = take_op && ret_op && !fault_op;

    chip8_call_stack #(
        .DEPTH(STACK_DEPTH)
    ) u_stack (
        .clk      (cpu_clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_data(seq_pc),
        .top      (stack_top),
        .count    (stack_count),
        .full     (stack_full),
        .empty    (stack_empty)
    );

    // High byte is staged in hi_byte so instr stays stable until the low byte lands.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state       <= FETCH_HI;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_valid <= 1'b0;
            hi_byte     <= '0;
`ifdef CHIP8_STACK_GUARD_EN
            stack_fault <= 1'b0;
`endif
        end else begin
            case (state)
                FETCH_HI: begin
                    if (mem_ack) begin
                        hi_byte <= mem_rdata;
                        state   <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (mem_ack) begin
                        instr       <= {hi_byte, mem_rdata};
                        instr_valid <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (pc_op_valid) begin
                        instr_valid <= 1'b0;
                        if (fault_op) begin
`ifdef CHIP8_STACK_GUARD_EN
                            state       <= FAULT;
                            stack_fault <= 1'b1;
`endif
                        end else begin
                            pc    <= pc_next;
                            state <= FETCH_HI;
                        end
                    end
                end
`ifdef CHIP8_STACK_GUARD_EN
                FAULT: state <= FAULT;
`endif
                default: state <= FETCH_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_fetch_sequencer.sv
// Directed self-checking bench for chip8_fetch_sequencer with a byte-array memory
// model and an architectural PC/stack model; honours CHIP8_STACK_GUARD_EN.
module tb_chip8_fetch_sequencer;

    localparam int unsigned STACK_DEPTH = 16;
`ifdef CHIP8_STACK_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        cpu_clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [11:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] instr;
    logic        instr_valid;
    logic        pc_op_valid = 1'b0;
    logic [2:0]  pc_op = 3'd0;
    logic [11:0] pc_target = 12'h000;
    logic [11:0] pc;
    logic [3:0]  sp;
`ifdef CHIP8_STACK_GUARD_EN
    logic        stack_fault;
`endif

    chip8_fetch_sequencer #(
        .RESET_PC   (12'h200),
        .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .cpu_clk    (cpu_clk),
        .reset      (reset),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc_op_valid(pc_op_valid),
        .pc_op      (pc_op),
        .pc_target  (pc_target),
        .pc         (pc),
        .sp         (sp)
`ifdef CHIP8_STACK_GUARD_EN
        ,
        .stack_fault(stack_fault)
`endif
    );

    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int failures = 0;

    // Memory model and responder controls
    logic [7:0] mem [4096];
    int         resp_wait = 0;
    int         resp_cnt = 0;
    bit         force_ack = 1'b0;

    // Architectural model
    logic [11:0] mpc = 12'h200;
    logic [11:0] mstack [$];
    bit          mfault = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_sp();
        return 4'(mstack.size() % STACK_DEPTH);
    endfunction

    task automatic model_apply(input logic [2:0] op, input logic [11:0] tgt);
        case (op)
            3'd1: mpc = mpc + 12'd4;
            3'd2: mpc = tgt;
            3'd3: begin
                if (GUARD && mstack.size() == STACK_DEPTH - 1) begin
                    mfault = 1'b1;
                end else begin
                    mstack.push_back(mpc + 12'd2);
                    mpc = tgt;
                end
            end
            3'd4: begin
                if (mstack.size() == 0) begin
                    if (GUARD) mfault = 1'b1;
                end else begin
                    mpc = mstack.pop_back();
                end
            end
            default: mpc = mpc + 12'd2;
        endcase
    endtask

    // Byte-wide memory: acks after resp_wait idle cycles, or unconditionally when forced.
    always @(negedge cpu_clk) begin
        if (force_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 8'hEE;
        end else if (mem_req) begin
            if (resp_cnt >= resp_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                resp_cnt  = 0;
            end else begin
                mem_ack = 1'b0;
                resp_cnt++;
            end
        end else begin
            mem_ack  = 1'b0;
            resp_cnt = 0;
        end
    end

    // Every out-of-reset cycle: PC/SP follow the model, held instr is the bytes at PC.
    always @(negedge cpu_clk) begin
        if (!reset) begin
            chk("model_pc", 32'(pc), 32'(mpc));
            chk("model_sp", 32'(sp), 32'(exp_sp()));
            if (instr_valid) begin
                chk("model_instr", 32'(instr), 32'({mem[mpc], mem[mpc + 12'd1]}));
            end
            if (mem_req) begin
                checks++;
                if (mem_addr !== mpc && mem_addr !== (mpc + 12'd1)) begin
                    failures++;
                    $display("FAIL model_addr: got %0h expected %0h or %0h",
                             mem_addr, mpc, mpc + 12'd1);
                end
            end
`ifdef CHIP8_STACK_GUARD_EN
            chk("model_fault", 32'(stack_fault), 32'(mfault));
            if (mfault) chk("model_fault_req", 32'(mem_req), 32'd0);
`endif
        end
    end

    task automatic wait_valid(input string tag, output bit ok);
        int n = 0;
        while (!instr_valid && n < 50) begin
            @(posedge cpu_clk);
            #1;
            n++;
        end
        ok = instr_valid;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: instr_valid got 0 expected 1 within 50 cycles", tag);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that took the op.
    task automatic do_op(input logic [2:0] op, input logic [11:0] tgt, input string tag);
        bit ok;
        wait_valid(tag, ok);
        if (!ok) return;
        pc_op_valid = 1'b1;
        pc_op       = op;
        pc_target   = tgt;
        @(posedge cpu_clk);
        model_apply(op, tgt);
        #1;
        pc_op_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        pc_op_valid = 1'b0;
        force_ack   = 1'b0;
        resp_wait   = 0;
        repeat (2) @(posedge cpu_clk);
        #1;
        reset = 1'b0;
        mpc   = 12'h200;
        mstack.delete();
        mfault = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
        mem[12'h200] = 8'h12;
        mem[12'h201] = 8'h34;
        mem[12'h202] = 8'h6A;
        mem[12'h203] = 8'h07;
        mem[12'hFFF] = 8'hC3;
        mem[12'h000] = 8'h3C;

        // Reset state
        @(negedge cpu_clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", 32'(instr), 32'h0000);
        chk("rst_pc", 32'(pc), 32'h200);
        chk("rst_sp", 32'(sp), 32'd0);
        @(posedge cpu_clk);
        #1;
        reset = 1'b0;

        // Zero-wait first fetch: HOLD reached in the third cycle
        @(negedge cpu_clk);
        chk("c1_req", 32'(mem_req), 32'd1);
        chk("c1_addr", 32'(mem_addr), 32'h200);
        @(negedge cpu_clk);
        chk("c2_addr", 32'(mem_addr), 32'h201);
        chk("c2_valid", 32'(instr_valid), 32'd0);
        @(negedge cpu_clk);
        chk("c3_valid", 32'(instr_valid), 32'd1);
        chk("c3_instr", 32'(instr), 32'h1234);
        chk("c3_pc", 32'(pc), 32'h200);

        // Acks with no request outstanding are ignored
        @(posedge cpu_clk);
        #1;
        force_ack = 1'b1;
        repeat (2) @(negedge cpu_clk);
        @(posedge cpu_clk);
        #1;
        force_ack = 1'b0;
        chk("stray_ack_instr", 32'(instr), 32'h1234);
        chk("stray_ack_valid", 32'(instr_valid), 32'd1);

        do_op(3'd0, 12'h000, "next_202");
        wait_valid("fetch_202", ok);
        chk("instr_202", 32'(instr), 32'h6A07);

        // Four-cycle ack delay: request and address held, instr untouched
        resp_wait = 4;
        do_op(3'd2, 12'h200, "jump_200");
        for (int i = 0; i < 4; i++) begin
            @(negedge cpu_clk);
            chk("stall_req", 32'(mem_req), 32'd1);
            chk("stall_addr", 32'(mem_addr), 32'h200);
            chk("stall_instr", 32'(instr), 32'h6A07);
        end
        @(posedge cpu_clk);
        #1;
        resp_wait = 0;
        wait_valid("fetch_stall", ok);
        chk("stall_done_instr", 32'(instr), 32'h1234);

        // CALL / RET round trip
        do_op(3'd0, 12'h000, "next_a");
        do_op(3'd0, 12'h000, "next_b");
        chk("pc_204", 32'(pc), 32'h204);
        do_op(3'd3, 12'h300, "call_300");
        chk("call_pc", 32'(pc), 32'h300);
        chk("call_sp", 32'(sp), 32'd1);
        do_op(3'd4, 12'h000, "ret");
        chk("ret_pc", 32'(pc), 32'h206);
        chk("ret_sp", 32'(sp), 32'd0);

        // pc_op_valid outside HOLD is ignored
        resp_wait = 3;
        do_op(3'd0, 12'h000, "next_208");
        pc_op_valid = 1'b1;
        pc_op       = 3'd2;
        pc_target   = 12'hABC;
        repeat (2) @(posedge cpu_clk);
        #1;
        pc_op_valid = 1'b0;
        resp_wait   = 0;
        wait_valid("fetch_208", ok);
        chk("ignored_op_pc", 32'(pc), 32'h208);

        // Address-space wrap
        do_op(3'd2, 12'hFFC, "jump_ffc");
        do_op(3'd1, 12'h000, "skip_ffc");
        chk("skip_wrap_pc", 32'(pc), 32'h000);
        do_op(3'd2, 12'hFFE, "jump_ffe");
        do_op(3'd0, 12'h000, "next_ffe");
        chk("next_wrap_pc", 32'(pc), 32'h000);
        do_op(3'd2, 12'hFFF, "jump_fff");
        wait_valid("fetch_fff", ok);
        chk("wrap_fetch_instr", 32'(instr), 32'hC33C);

        // Sixteen nested calls
        for (int i = 0; i < 16; i++) begin
            do_op(3'd3, 12'h400 + 12'(i * 16), "call_chain");
        end
`ifdef CHIP8_STACK_GUARD_EN
        chk("guard_fault", 32'(stack_fault), 32'd1);
        chk("guard_pc", 32'(pc), 32'h4E0);
        chk("guard_sp", 32'(sp), 32'd15);
        @(negedge cpu_clk);
        chk("guard_req", 32'(mem_req), 32'd0);
        chk("guard_valid", 32'(instr_valid), 32'd0);
`else
        chk("wrap_sp", 32'(sp), 32'd0);
        chk("wrap_pc", 32'(pc), 32'h4F0);
        do_op(3'd4, 12'h000, "ret_after_wrap");
        chk("wrap_ret_pc", 32'(pc), 32'h4E2);
        chk("wrap_ret_sp", 32'(sp), 32'd15);
`endif

        // Reset during FETCH_LO with an ack in the reset cycle
        do_reset();
        do_op(3'd0, 12'h000, "next_pre_rst");
        @(posedge cpu_clk);
        #1;
        reset     = 1'b1;
        force_ack = 1'b1;
        @(negedge cpu_clk);
        chk("rst_cycle_req", 32'(mem_req), 32'd0);
        @(posedge cpu_clk);
        #1;
        reset     = 1'b0;
        force_ack = 1'b0;
        mpc       = 12'h200;
        mstack.delete();
        mfault = 1'b0;
        chk("midrst_instr", 32'(instr), 32'h0000);
        chk("midrst_pc", 32'(pc), 32'h200);
        chk("midrst_valid", 32'(instr_valid), 32'd0);
        wait_valid("refetch", ok);
        chk("refetch_instr", 32'(instr), 32'h1234);
        chk("refetch_pc", 32'(pc), 32'h200);

        @(posedge cpu_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
